mac_arbiter: RTL and testbench

Round-robin scheduler that shares one pipelined multiply-add unit (DATA_OUT = A*B + C, fixed 3-cycle latency, no valid/stall) among NREQ requesters. The block accepts at most one operand set per cycle and registers it onto the unit's A/B/C inputs. It tracks the requester ID of every in-flight operation and returns each result, tagged with that ID, on a shared response port. It sits between the requesting blocks and the multiply-add instance, and the instance's ports connect directly to mac_a/mac_b/mac_c/mac_out.

---
 rtl/mac_arbiter.sv | 127 ++++++++++++
 tb/tb_mac_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin front end for a shared, fixed-latency multiply-add
// unit. Grants one requester per cycle, registers its operands onto the unit,
// and tags each in-flight operation so results return with the requester ID.
module mac_arbiter #(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 4,
    parameter  int LAT   = 3,
    localparam int IDW   = $clog2(NREQ),
    localparam int IFW   = $clog2(LAT + 2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*WIDTH-1:0] req_c,
    output logic [WIDTH-1:0]      mac_a,
    output logic [WIDTH-1:0]      mac_b,
    output logic [WIDTH-1:0]      mac_c,
    input  logic [2*WIDTH-1:0]    mac_out,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_data,
    output logic [IFW-1:0]        inflight,
    output logic                  idle
);

    // Tag stages: operand register, LAT unit stages, and the unit's output
    // update, so the tail lines up with the cycle mac_out carries the result.
    localparam int DEPTH = LAT + 2;

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   gnt_idx;
    logic             xfer;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] sel_c;
    logic [DEPTH-1:0] tag_v;
    logic [IDW-1:0]   tag_id [DEPTH];

    // Round-robin pick: first valid requester searching from ptr+1 upward.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        cand      = '0;
        gnt_idx   = '0;
        xfer      = 1'b0;
        req_ready = '0;
        if (en && !rst) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = IDW'((int'(ptr) + k) % NREQ);
                if (!xfer && req_valid[cand]) begin
                    xfer    = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        if (xfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
                sel_c = req_c[i*WIDTH +: WIDTH];
            end
        end
    end

    // Control state: pointer, operand registers, tag valids, response, count.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            ptr       <= IDW'(NREQ - 1);
            mac_a     <= '0;
            mac_b     <= '0;
            mac_c     <= '0;
            tag_v     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            inflight  <= '0;
        end else begin
            if (xfer) begin
                ptr   <= gnt_idx;
                mac_a <= sel_a;
                mac_b <= sel_b;
                mac_c <= sel_c;
            end
            tag_v     <= {tag_v[DEPTH-2:0], xfer};
            rsp_valid <= tag_v[DEPTH-1];
            if (tag_v[DEPTH-1]) begin
                rsp_id   <= tag_id[DEPTH-1];
                rsp_data <= mac_out;
            end
            case ({xfer, rsp_valid})
                2'b10:   inflight <= inflight + IFW'(1);
                2'b01:   inflight <= inflight - IFW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Tag ID shift register, qualified by tag_v at every stage.
    always_ff @(posedge clk) begin
        // NOTE: the ID array has no reset; its contents are only used when
        // the matching valid bit is set, and that bit is reset.
        tag_id[0] <= gnt_idx;
        for (int i = 1; i < DEPTH; i++) begin
            tag_id[i] <= tag_id[i-1];
        end
    end

    assign idle = (inflight == '0) && !xfer;

endmodule

// File: tb/tb_mac_arbiter.sv
// tb_mac_arbiter: scenario tasks plus a queue-based scoreboard and a
// behavioural model of the shared multiply-add unit.
module tb_mac_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int LAT   = 3;
    localparam int WW    = 2 * WIDTH;
    localparam int IDW   = $clog2(NREQ);
    localparam int IFW   = $clog2(LAT + 2);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a, req_b, req_c;
    logic [WIDTH-1:0]      mac_a, mac_b, mac_c;
    logic [WW-1:0]         mac_out;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WW-1:0]         rsp_data;
    logic [IFW-1:0]        inflight;
    logic                  idle;

    int vectors    = 0;
    int miscompares = 0;

    mac_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_out(mac_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .inflight(inflight), .idle(idle)
    );

    always #5 clk = ~clk;

    // Multiply-add unit: samples operands one edge after they are registered
    // and shows the result LAT edges later.
    logic [WW-1:0] unit_pipe [0:LAT];
    always @(posedge clk) begin
        unit_pipe[0] <= WW'(mac_a) * WW'(mac_b) + WW'(mac_c);
        for (int i = 1; i <= LAT; i++) unit_pipe[i] <= unit_pipe[i-1];
    end
    assign mac_out = unit_pipe[LAT];

    // Reference model: round-robin pointer and a queue of expected responses.
    typedef struct {
        int            id;
        logic [WW-1:0] data;
        int            due;
    } exp_t;

    exp_t exp_q[$];
    int   ptr_m = NREQ - 1;
    int   cyc   = 0;

    function automatic int rr_pick();
        int idx;
        if (rst || !en) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (ptr_m + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // Grant check every cycle, away from the clock edge.
    always @(negedge clk) begin
        int g;
        logic [NREQ-1:0] exp_ready;
        g = rr_pick();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        vectors++;
        if (req_ready !== exp_ready) begin
            miscompares++;
            $display("FAIL monitor_ready cyc=%0d: got %b expected %b", cyc, req_ready, exp_ready);
        end
    end

    // Transfer capture at the edge, response check just after it.
    always @(posedge clk) begin
        int   g;
        exp_t e;
        g = rr_pick();
        cyc++;
        if (rst) begin
            ptr_m = NREQ - 1;
            exp_q.delete();
        end else if (g >= 0) begin
            ptr_m  = g;
            e.id   = g;
            e.data = WW'(req_a[g*WIDTH +: WIDTH]) * WW'(req_b[g*WIDTH +: WIDTH])
                   + WW'(req_c[g*WIDTH +: WIDTH]);
            e.due  = cyc + LAT + 2;
            exp_q.push_back(e);
        end
        #1;
        vectors++;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            if (rsp_valid !== 1'b1 || int'(rsp_id) != e.id || rsp_data !== e.data) begin
                miscompares++;
                $display("FAIL monitor_rsp cyc=%0d: got v=%b id=%0d data=%0d expected v=1 id=%0d data=%0d",
                         cyc, rsp_valid, rsp_id, rsp_data, e.id, e.data);
            end
        end else if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL monitor_rsp cyc=%0d: got unexpected rsp_valid=%b", cyc, rsp_valid);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b, input int c);
        req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
        req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
        req_c[i*WIDTH +: WIDTH] = WIDTH'(c);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req_valid = '1;
        tick(); tick();
        @(negedge clk);
        vectors++;
        if (req_ready !== '0) begin
            miscompares++; $display("FAIL reset_ready: got %b expected 0", req_ready);
        end
        vectors++;
        if (mac_a !== '0 || mac_b !== '0 || mac_c !== '0 || rsp_valid !== 1'b0 ||
            rsp_id !== '0 || rsp_data !== '0 || inflight !== '0 || idle !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: got a=%0d b=%0d c=%0d v=%b id=%0d d=%0d inf=%0d idle=%b expected zeros, idle=1",
                     mac_a, mac_b, mac_c, rsp_valid, rsp_id, rsp_data, inflight, idle);
        end
        tick();
        rst = 1'b0; req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        set_op(2, 3, 4, 5);
        req_valid = 4'b0100;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++; $display("FAIL single_ready: got %b expected 0100", req_ready);
        end
        tick();
        req_valid = '0;
        vectors++;
        if (inflight !== IFW'(1) || mac_a !== 8'd3 || mac_b !== 8'd4 || mac_c !== 8'd5) begin
            miscompares++;
            $display("FAIL single_issue: got inf=%0d a=%0d b=%0d c=%0d expected 1 3 4 5", inflight, mac_a, mac_b, mac_c);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            vectors++;
            if (k < 5 && rsp_valid !== 1'b0) begin
                miscompares++; $display("FAIL single_early: edge %0d got rsp_valid=1 expected 0", k);
            end
            if (k == 5 && (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 16'd17)) begin
                miscompares++;
                $display("FAIL single_rsp: got v=%b id=%0d data=%0d expected 1 2 17", rsp_valid, rsp_id, rsp_data);
            end
        end
        tick();
        vectors++;
        if (inflight !== '0 || idle !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drain: got inf=%0d idle=%b v=%b expected 0 1 0", inflight, idle, rsp_valid);
        end
    endtask

    task automatic test_all_four();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 2, i);
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== 4'(1 << i)) begin
                miscompares++; $display("FAIL all4_grant%0d: got %b expected %b", i, req_ready, 4'(1 << i));
            end
            tick();
        end
        req_valid = '0;
        tick();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL all4_early: got rsp_valid=1 expected 0");
        end
        for (int j = 0; j < NREQ; j++) begin
            tick();
            vectors++;
            if (rsp_valid !== 1'b1 || int'(rsp_id) != j || int'(rsp_data) != 3 * j + 2) begin
                miscompares++;
                $display("FAIL all4_rsp%0d: got v=%b id=%0d data=%0d expected 1 %0d %0d",
                         j, rsp_valid, rsp_id, rsp_data, j, 3 * j + 2);
            end
        end
        tick();
    endtask

    task automatic test_max_operands();
        set_op(0, 255, 255, 255);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        repeat (5) tick();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'hFF00) begin
            miscompares++;
            $display("FAIL max_rsp: got v=%b id=%0d data=%h expected 1 0 ff00", rsp_valid, rsp_id, rsp_data);
        end
        repeat (2) tick();
    endtask

    task automatic test_fairness_en();
        int rsp_cnt = 0;
        for (int i = 0; i < NREQ; i++) set_op(i, i + 2, 3, 1);
        req_valid = 4'b1010;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++; $display("FAIL fair_g0: got %b expected 0010", req_ready);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b1000) begin
            miscompares++; $display("FAIL fair_g1: got %b expected 1000", req_ready);
        end
        tick();
        req_valid = 4'b0010;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++; $display("FAIL fair_g2: got %b expected 0010", req_ready);
        end
        tick();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== '0) begin
                miscompares++; $display("FAIL en_off_ready: got %b expected 0", req_ready);
            end
            tick();
            if (rsp_valid) rsp_cnt++;
        end
        repeat (4) begin
            tick();
            if (rsp_valid) rsp_cnt++;
        end
        @(negedge clk);
        vectors++;
        if (rsp_cnt != 3 || idle !== 1'b1 || inflight !== '0) begin
            miscompares++;
            $display("FAIL en_off_drain: got rsps=%0d idle=%b inf=%0d expected 3 1 0", rsp_cnt, idle, inflight);
        end
        tick();
        en = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++; $display("FAIL en_resume: got %b expected 0010", req_ready);
        end
        tick();
        req_valid = '0;
        repeat (7) tick();
    endtask

    task automatic test_reset_midflight();
        int rsp_cnt = 0;
        set_op(0, 9, 9, 9);
        req_valid = 4'b0001;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (inflight !== '0 || mac_a !== '0 || mac_b !== '0 || mac_c !== '0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_state: got inf=%0d a=%0d b=%0d c=%0d v=%b expected zeros",
                     inflight, mac_a, mac_b, mac_c, rsp_valid);
        end
        set_op(0, 7, 8, 9);
        set_op(3, 1, 1, 1);
        req_valid = 4'b1001;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL midrst_first: got %b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        repeat (8) begin
            tick();
            if (rsp_valid) rsp_cnt++;
        end
        vectors++;
        if (rsp_cnt != 1) begin
            miscompares++; $display("FAIL midrst_rsps: got %0d responses expected 1", rsp_cnt);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            req_valid = NREQ'($urandom);
            en = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < NREQ; i++)
                set_op(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            tick();
        end
        req_valid = '0;
        en = 1'b1;
        repeat (8) tick();
        vectors++;
        if (idle !== 1'b1 || inflight !== '0) begin
            miscompares++; $display("FAIL random_drain: got idle=%b inf=%0d expected 1 0", idle, inflight);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req_valid = '0;
        req_a = '0; req_b = '0; req_c = '0;
        test_reset();
        test_single();
        test_all_four();
        test_max_operands();
        test_fairness_en();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
